// File: rtl/sample_scheduler_if.sv
// ============================================================================
// Module      : sample_scheduler_if
// Description : Buffer/transmitter/host signal bundle for sample_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sample_scheduler_if #(
    parameter int WIDTH = 24
);
    logic             enable;
    logic             word_valid;
    logic [WIDTH-1:0] buf_data;
    logic             tx_req;
    logic             clr_status;
    logic             pop;
    logic [WIDTH-1:0] sample_out;
    logic             sample_valid;
    logic             channel;
    logic [6:0]       level;
    logic             rpi_interrupt;
    logic             underrun;
    logic             overflow;
    logic             late;

    // Master is the environment (buffer, transmitter, host); slave is the scheduler.
    modport master (
        output enable, word_valid, buf_data, tx_req, clr_status,
        input  pop, sample_out, sample_valid, channel, level,
        input  rpi_interrupt, underrun, overflow, late
    );

    modport slave (
        input  enable, word_valid, buf_data, tx_req, clr_status,
        output pop, sample_out, sample_valid, channel, level,
        output rpi_interrupt, underrun, overflow, late
    );
endinterface

`default_nettype wire

// File: rtl/sample_scheduler.sv
// ============================================================================
// Module      : sample_scheduler
// Description : Paces buffered audio words out to a stereo transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_scheduler #(
    parameter int WIDTH   = 24,
    parameter int DEPTH   = 64,
    parameter int LOW_WM  = 16,
    parameter int HIGH_WM = 48
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sample_scheduler_if.slave bus
);

    localparam logic [6:0] DEPTH_LVL = 7'(DEPTH);
    localparam logic [6:0] LOW_LVL   = 7'(LOW_WM);
    localparam logic [6:0] HIGH_LVL  = 7'(HIGH_WM);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        POP      = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       pop_set;
    logic       latch_set;
    logic       under_set;
    logic       late_set;
    logic       overflow_set;
    logic [6:0] level_next;
    logic       rpi_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Disabling in WAIT_REQ takes priority over a same-cycle request.
    always_comb begin
        state_next = state;
        pop_set    = 1'b0;
        latch_set  = 1'b0;
        under_set  = 1'b0;
        late_set   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_next = WAIT_REQ;
                end
            end
            WAIT_REQ: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end else if (bus.tx_req) begin
                    if (bus.level != 7'd0) begin
                        state_next = POP;
                    end else begin
                        under_set = 1'b1;
                    end
                end
            end
            POP: begin
                pop_set    = 1'b1;
                late_set   = bus.tx_req;
                state_next = LATCH;
            end
            LATCH: begin
                latch_set  = 1'b1;
                late_set   = bus.tx_req;
                state_next = bus.enable ? WAIT_REQ : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Interrupt hysteresis follows the post-update level so it moves with level.
    always_comb begin
        level_next   = bus.level;
        overflow_set = 1'b0;
        if (bus.word_valid && !bus.pop) begin
            if (bus.level == DEPTH_LVL) begin
                overflow_set = 1'b1;
            end else begin
                level_next = bus.level + 7'd1;
            end
        end else if (bus.pop && !bus.word_valid && (bus.level != 7'd0)) begin
            level_next = bus.level - 7'd1;
        end

        rpi_next = bus.rpi_interrupt;
        if (level_next <= LOW_LVL) begin
            rpi_next = 1'b1;
        end else if (level_next >= HIGH_LVL) begin
            rpi_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pop           <= 1'b0;
            bus.sample_out    <= '0;
            bus.sample_valid  <= 1'b0;
            bus.channel       <= 1'b0;
            bus.level         <= 7'd0;
            bus.rpi_interrupt <= 1'b1;
            bus.underrun      <= 1'b0;
            bus.overflow      <= 1'b0;
            bus.late          <= 1'b0;
        end else begin
            bus.pop          <= pop_set;
            bus.sample_valid <= latch_set | under_set;
            if (latch_set) begin
                bus.sample_out <= bus.buf_data;
            end else if (under_set) begin
                bus.sample_out <= '0;
            end
            if (bus.sample_valid) begin
                bus.channel <= ~bus.channel;
            end
            bus.level         <= level_next;
            bus.rpi_interrupt <= rpi_next;
            bus.underrun      <= under_set    | (bus.underrun & ~bus.clr_status);
            bus.overflow      <= overflow_set | (bus.overflow & ~bus.clr_status);
            bus.late          <= late_set     | (bus.late     & ~bus.clr_status);
        end
    end

endmodule

`default_nettype wire

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning sample word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning sample buffer capacity in words.
REQ-003 The block SHALL have parameter LOW_WM, default 16, meaning level at or below which rpi_interrupt sets.
REQ-004 The block SHALL have parameter HIGH_WM, default 48, meaning level at or above which rpi_interrupt clears.
REQ-005 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port enable  input  1  playback enable.
REQ-008 The block SHALL have port word_valid  input  1  one-cycle pulse: upstream wrote one word into the buffer.
REQ-009 The block SHALL have port buf_data  input  WIDTH  head word of the buffer, valid one cycle after pop.
REQ-010 The block SHALL have port tx_req  input  1  one-cycle pulse: transmitter requests the next sample.
REQ-011 The block SHALL have port clr_status  input  1  one-cycle pulse clearing the sticky flags.
REQ-012 The block SHALL have port pop  output  1  one-cycle pulse advancing the buffer read pointer.
REQ-013 The block SHALL have port sample_out  output  WIDTH  sample presented to the transmitter.
REQ-014 The block SHALL have port sample_valid  output  1  one-cycle pulse qualifying sample_out.
REQ-015 The block SHALL have port channel  output  1  channel of the current sample: 0 left, 1 right.
REQ-016 The block SHALL have port level  output  7  count of words held in the buffer, 0..DEPTH.
REQ-017 The block SHALL have port rpi_interrupt  output  1  refill request to the host.
REQ-018 The block SHALL have ports underrun, overflow, late  output  1 each  sticky error flags.

Function
REQ-019 The block SHALL implement states IDLE, WAIT_REQ, POP, LATCH.
- IDLE->WAIT_REQ when enable=1.
- WAIT_REQ->POP on tx_req with level>0.
- POP->LATCH unconditionally.
- LATCH->WAIT_REQ, or ->IDLE if enable=0.
REQ-020 The block SHALL, on tx_req at edge N in WAIT_REQ with level>0, assert pop for the cycle after edge N+1 and assert sample_valid with sample_out=buf_data for the cycle after edge N+2.
REQ-021 The block SHALL, on tx_req in WAIT_REQ with level=0, present sample_out=0 with sample_valid one cycle later, issue no pop, set underrun, and remain in WAIT_REQ.
REQ-022 The block SHALL hold sample_out between samples and toggle channel on the cycle each sample_valid pulse ends, including zero-filled underrun samples.
REQ-023 The block SHALL ignore tx_req in POP, LATCH or IDLE(enable=1 transition cycle excluded) and set late.
REQ-024 The block SHALL ignore tx_req in IDLE with enable=0 without setting any flag.
REQ-025 The block SHALL update level: +1 on word_valid only, -1 on pop only, unchanged when both occur in the same cycle.
REQ-026 The block SHALL, on word_valid with level=DEPTH and no same-cycle pop, hold level at DEPTH and set overflow.
REQ-027 The block SHALL set rpi_interrupt when level<=LOW_WM and clear it when level>=HIGH_WM, holding its value in between (hysteresis).
REQ-028 The block SHALL, on enable deassert in WAIT_REQ, enter IDLE next cycle; a transaction in POP/LATCH SHALL complete first.
REQ-029 The block SHALL track level and rpi_interrupt in every state, including IDLE.
REQ-030 The block SHALL clear all sticky flags on clr_status; a set condition in the same cycle SHALL win.

Reset
REQ-031 The block SHALL, while reset=1, force state IDLE, pop=0, sample_out=0, sample_valid=0, channel=0, level=0, rpi_interrupt=1, underrun=overflow=late=0.
REQ-032 The block SHALL, on reset asserted mid-transaction, abandon it with no pop or sample_valid issued afterwards.

Verification
REQ-033 Bench: reset, enable=1, 20 word_valid pulses, tx_req -> pop 2 cycles after tx_req, sample_valid 3 cycles after, level 20->19, channel 0->1.
REQ-034 Bench: level=0, tx_req -> sample_out=0, sample_valid 1 cycle later, underrun=1, no pop, level stays 0.
REQ-035 Bench: fill 0->48 -> rpi_interrupt 1 until level=48, then 0; drain to 16 -> rpi_interrupt 1 at level=16.
REQ-036 Bench: level=64, word_valid alone -> overflow=1, level 64; word_valid with pop -> level unchanged, no overflow.
REQ-037 Bench: tx_req one cycle after an accepted tx_req -> late=1, single sample delivered; clr_status -> late=0.
REQ-038 Bench: reset asserted in POP state -> all outputs at reset values next sample point, no sample_valid.
